// File: rtl/alu_share_arb.sv
// alu_share_arb
// Shares one external combinational ALU between two requesters with a
// round-robin grant. Each accepted request is run through the ALU from
// registered operands for one cycle. The result and zero flag are then held on
// the owner's response channel until that channel is acknowledged.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   reqN_valid/ready              request handshake (ready is combinational)
//   reqN_a, reqN_b, reqN_op       operands and opcode (opcode passed unmodified)
//   rspN_valid/ready              response handshake, held until consumed
//   rspN_result, rspN_z           captured ALU result and zero flag
//   alu_srca, alu_srcb, alu_ctrl  registered drive to the external ALU
//   alu_result, alu_z             external ALU outputs
//   busy                          high whenever the FSM is not IDLE
module alu_share_arb #(
  parameter int DWIDTH = 32,
  parameter int CWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DWIDTH-1:0] req0_a,
  input  logic [DWIDTH-1:0] req0_b,
  input  logic [CWIDTH-1:0] req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DWIDTH-1:0] req1_a,
  input  logic [DWIDTH-1:0] req1_b,
  input  logic [CWIDTH-1:0] req1_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DWIDTH-1:0] rsp0_result,
  output logic              rsp0_z,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DWIDTH-1:0] rsp1_result,
  output logic              rsp1_z,
  output logic [DWIDTH-1:0] alu_srca,
  output logic [DWIDTH-1:0] alu_srcb,
  output logic [CWIDTH-1:0] alu_ctrl,
  input  logic [DWIDTH-1:0] alu_result,
  input  logic              alu_z,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_r;
  logic   owner_r;
  logic   last_grant_r;

  logic   grant_s;
  logic   accept_s;
  logic   rsp_ack_s;

  // Round-robin winner: on a tie the requester that did not win last time is
  // chosen; a lone valid requester always wins.
  always_comb begin
    grant_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_s = ~last_grant_r;
    end else begin
      grant_s = req1_valid;
    end
  end

  // Request ready strobes and accept detection, only meaningful in IDLE.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept_s   = 1'b0;
    if ((state_r == IDLE) && !rst) begin
      req0_ready = ~grant_s;
      req1_ready = grant_s;
      accept_s   = grant_s ? req1_valid : req0_valid;
    end else begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      accept_s   = 1'b0;
    end
  end

  // Response acknowledge: only the owner's ready counts, and only once valid.
  always_comb begin
    rsp_ack_s = 1'b0;
    if (owner_r) begin
      rsp_ack_s = rsp1_valid & rsp1_ready;
    end else begin
      rsp_ack_s = rsp0_valid & rsp0_ready;
    end
  end

  // Sequencer FSM: accept -> one ALU cycle -> hold response until consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      owner_r      <= 1'b0;
      last_grant_r <= 1'b1;
      alu_srca     <= {DWIDTH{1'b0}};
      alu_srcb     <= {DWIDTH{1'b0}};
      alu_ctrl     <= {CWIDTH{1'b0}};
      rsp0_valid   <= 1'b0;
      rsp0_result  <= {DWIDTH{1'b0}};
      rsp0_z       <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp1_result  <= {DWIDTH{1'b0}};
      rsp1_z       <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            // Operand regs only change here, so the ALU inputs stay put
            // through RESP and the following IDLE.
            alu_srca     <= grant_s ? req1_a  : req0_a;
            alu_srcb     <= grant_s ? req1_b  : req0_b;
            alu_ctrl     <= grant_s ? req1_op : req0_op;
            owner_r      <= grant_s;
            last_grant_r <= grant_s;
            state_r      <= EXEC;
            busy         <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          if (owner_r) begin
            rsp1_result <= alu_result;
            rsp1_z      <= alu_z;
            rsp1_valid  <= 1'b1;
          end else begin
            rsp0_result <= alu_result;
            rsp0_z      <= alu_z;
            rsp0_valid  <= 1'b1;
          end
          state_r <= RESP;
        end
        RESP: begin
          if (rsp_ack_s) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            state_r    <= IDLE;
            busy       <= 1'b0;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a behavioural model of the external ALU.
module tb_alu_share_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = 32'd0, req0_b = 32'd0, req1_a = 32'd0, req1_b = 32'd0;
  logic [3:0]  req0_op = 4'd0, req1_op = 4'd0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_z, rsp1_z;
  logic [31:0] alu_srca, alu_srcb, alu_result;
  logic [3:0]  alu_ctrl;
  logic        alu_z;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_arb #(.DWIDTH(32), .CWIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_z(rsp0_z),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_z(rsp1_z),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_z(alu_z),
    .busy(busy)
  );

  // External ALU model: 3 ADD, 4 SUB, 5 SLL, 8 SLTU, 15 default = pass SrcA.
  always_comb begin
    alu_result = alu_srca;
    case (alu_ctrl)
      4'd0:    alu_result = alu_srca & alu_srcb;
      4'd1:    alu_result = alu_srca | alu_srcb;
      4'd2:    alu_result = alu_srca ^ alu_srcb;
      4'd3:    alu_result = alu_srca + alu_srcb;
      4'd4:    alu_result = alu_srca - alu_srcb;
      4'd5:    alu_result = alu_srca << alu_srcb[4:0];
      4'd6:    alu_result = alu_srca >> alu_srcb[4:0];
      4'd8:    alu_result = {31'd0, (alu_srca < alu_srcb)};
      default: alu_result = alu_srca;
    endcase
    alu_z = (alu_result == 32'd0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] exp_res;
    logic        exp_z;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b0, 32'd5,         32'd7, 4'd3,  32'd12,        1'b0}; // ADD
    vecs[1] = '{1'b1, 32'd3,         32'd3, 4'd4,  32'd0,         1'b1}; // SUB -> Z
    vecs[2] = '{1'b0, 32'hFFFF_FFFF, 32'd1, 4'd15, 32'hFFFF_FFFF, 1'b0}; // default op
    vecs[3] = '{1'b1, 32'd1,         32'd2, 4'd5,  32'd4,         1'b0}; // SLL
    vecs[4] = '{1'b0, 32'd1,         32'd2, 4'd8,  32'd1,         1'b0}; // SLTU
    vecs[5] = '{1'b1, 32'd5,         32'd5, 4'd0,  32'd5,         1'b0}; // AND

    // Reset state
    #2;
    chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("rst_alu_srca", alu_srca, 32'd0);
    chk("rst_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp0_result", rsp0_result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven single transactions, rsp_ready held high
    for (int i = 0; i < 6; i++) begin
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      if (vecs[i].sel) begin
        req1_valid = 1'b1; req1_a = vecs[i].a; req1_b = vecs[i].b; req1_op = vecs[i].op;
      end else begin
        req0_valid = 1'b1; req0_a = vecs[i].a; req0_b = vecs[i].b; req0_op = vecs[i].op;
      end
      #1;
      chk($sformatf("v%0d_ready", i), {30'd0, req1_ready, req0_ready},
          vecs[i].sel ? 32'd2 : 32'd1);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk($sformatf("v%0d_exec_busy", i), {31'd0, busy}, 32'd1);
      chk($sformatf("v%0d_srca", i), alu_srca, vecs[i].a);
      chk($sformatf("v%0d_srcb", i), alu_srcb, vecs[i].b);
      chk($sformatf("v%0d_ctrl", i), {28'd0, alu_ctrl}, {28'd0, vecs[i].op});
      chk($sformatf("v%0d_exec_rspv", i), {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_rspv", i), {30'd0, rsp1_valid, rsp0_valid},
          vecs[i].sel ? 32'd2 : 32'd1);
      chk($sformatf("v%0d_result", i), vecs[i].sel ? rsp1_result : rsp0_result,
          vecs[i].exp_res);
      chk($sformatf("v%0d_z", i), {31'd0, vecs[i].sel ? rsp1_z : rsp0_z},
          {31'd0, vecs[i].exp_z});
      chk($sformatf("v%0d_resp_busy", i), {31'd0, busy}, 32'd1);
      chk($sformatf("v%0d_resp_noready", i), {30'd0, req1_ready, req0_ready}, 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_idle_busy", i), {31'd0, busy}, 32'd0);
      chk($sformatf("v%0d_idle_rspv", i), {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    end
    // Non-owner registers keep their last captured values
    chk("keep_rsp1_result", rsp1_result, 32'd5);
    chk("keep_rsp0_result", rsp0_result, 32'd1);
    chk("hold_alu_srca_idle", alu_srca, 32'd5);

    // Contention from reset: grants 0,1,0,1 every 3 cycles
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_op = 4'd3;
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd2; req1_op = 4'd5;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      chk($sformatf("cont_acc_c%0d", cyc), {31'd0, (req0_ready | req1_ready)},
          (cyc % 3 == 0) ? 32'd1 : 32'd0);
      if (cyc % 3 == 0) begin
        chk($sformatf("cont_grant_c%0d", cyc), {30'd0, req1_ready, req0_ready},
            ((cyc / 3) % 2 == 1) ? 32'd2 : 32'd1);
      end else if (cyc % 3 == 2) begin
        if ((cyc / 3) % 2 == 1) begin
          chk($sformatf("cont_rsp1_c%0d", cyc), {rsp1_result[30:0], rsp1_valid}, {31'd4, 1'b1});
        end else begin
          chk($sformatf("cont_rsp0_c%0d", cyc), {rsp0_result[30:0], rsp0_valid}, {31'd3, 1'b1});
        end
      end else begin
        chk($sformatf("cont_exec_busy_c%0d", cyc), {31'd0, busy}, 32'd1);
      end
      @(negedge clk);
      #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Backpressure: SLTU held for 5 cycles with rsp0_ready low
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b1; // non-owner ready must be ignored
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_op = 4'd8;
    #1;
    chk("bp_accept", {31'd0, req0_ready}, 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_valid_%0d", k), {31'd0, rsp0_valid}, 32'd1);
      chk($sformatf("bp_result_%0d", k), rsp0_result, 32'd1);
      chk($sformatf("bp_noready_%0d", k), {30'd0, req1_ready, req0_ready}, 32'd0);
      @(negedge clk);
    end
    rsp0_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_busy", {31'd0, busy}, 32'd0);
    chk("bp_release_valid", {31'd0, rsp0_valid}, 32'd0);

    // Reset during EXEC: last grant was requester 0, reset must restore 1
    req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd2; req0_op = 4'd3;
    @(negedge clk);
    req0_valid = 1'b0;
    chk("mid_exec_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_srca", alu_srca, 32'd0);
    chk("mid_rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    chk("mid_rst_rspv", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("mid_no_rsp_%0d", k), {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    end
    chk("mid_rsp0_result_cleared", rsp0_result, 32'd0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("mid_tie_grant0", {30'd0, req1_ready, req0_ready}, 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Round-robin arbiter and sequencer that shares one ALU instance between two requesters, e.g. the main datapath and a secondary unit such as a branch/compare helper. It accepts operand/opcode requests over valid/ready handshakes and drives the ALU from registered operands. It captures the ALU result and zero flag one cycle later and returns them on a per-requester response channel held until acknowledged. The ALU itself stays combinational and external, and this block owns its inputs.

## Interface
- DWIDTH, 32, operand/result width
- CWIDTH, 4, ALU opcode width (ALUControl encoding)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_a, req0_b / req1_a, req1_b  in  DWIDTH  operands (SrcA, SrcB)
- req0_op / req1_op  in  CWIDTH  ALU opcode, passed unmodified
- rsp0_valid / rsp1_valid  out  1  response held
- rsp0_ready / rsp1_ready  in  1  response consumed
- rsp0_result / rsp1_result  out  DWIDTH  captured ALUResult
- rsp0_z / rsp1_z  out  1  captured Z flag
- alu_srca, alu_srcb  out  DWIDTH  to ALU SrcA/SrcB
- alu_ctrl  out  CWIDTH  to ALU ALUControl
- alu_result  in  DWIDTH  from ALU
- alu_z  in  1  from ALU Z
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - Select the winner among valid requesters. If both are valid, grant the one that is not `last_grant`.
  - `reqN_ready` = (state==IDLE) & grant==N & !rst. It is combinational, and at most one is high.
  - On valid&ready: latch a/b/op into operand regs, record `owner`=N, set `last_grant`=N, go to EXEC.
- EXEC:
  - The operand regs drive alu_srca/alu_srcb/alu_ctrl.
  - At the end of the cycle, capture alu_result/alu_z into `rspN_result`/`rspN_z` for the owner, set `rspN_valid`=1, and go to RESP.
- RESP:
  - `rsp<owner>_valid` stays high, and result/z are stable, until `rsp<owner>_ready`=1.
  - On handshake: clear valid and go to IDLE.
  - Requests are not accepted in EXEC or RESP. All req*_ready are 0.
- The opcode is not decoded or checked. Every value 0..15, including 15 (ALU default), is forwarded and its result returned.
- alu_* outputs hold their operand-reg values outside EXEC. Registers change only on accept.
- The non-owner response channel keeps valid=0. Its result/z registers keep their previous contents.
- Width rules:
  - Result/z are a straight copy of the ALU output. No extension or truncation.
  - `owner` and `last_grant` are 1 bit.

## Timing
- Reset values: rsp*_valid=0, rsp*_result=0, rsp*_z=0, req*_ready=0 (while rst=1), alu_srca=alu_srcb=0, alu_ctrl=0, busy=0, last_grant=1 (requester 0 wins the first tie), state=IDLE.
- Latency: for a request accepted at edge E, the operands reach the ALU after E, rsp_valid rises after E+1, and data is valid in the same cycle.
- Minimum spacing between accepts is 3 cycles (IDLE, EXEC, RESP with rsp_ready already high).
- A response handshake at edge F returns the FSM to IDLE after F. A new accept is possible at F+1.
- Simultaneous events:
  - Both valid in IDLE: only the round-robin winner sees ready. The loser keeps valid and must hold its inputs stable, and it wins the next IDLE tie.
  - A single valid requester is granted regardless of `last_grant`.
- rsp_ready asserted before rsp_valid has no effect.
- rsp_ready of the non-owner is ignored.
- Reset mid-operation (any state) clears immediately. The in-flight operation is discarded and no response is produced.
- The EXEC cycle budget is the ALU combinational path only: operand regs to alu_result to response regs.

## Test plan
- Single request: req0 a=5, b=7, op=3 (ADD), rsp0_ready=1. Expect req0_ready in cycle 0, rsp0_valid after edge 2 with result=12, z=0, and busy high for 2 cycles.
- Zero flag: req1 a=3, b=3, op=4 (SUB). Expect rsp1_result=0, rsp1_z=1, and rsp0_valid stays 0 throughout.
- Contention: req0 and req1 both valid continuously after reset with ops ADD(1,2) and SLL(1,2). Expect grant order 0,1,0,1, results 3 and 4 alternating, and accepts exactly every 3 cycles.
- Backpressure: req0 SLTU a=1, b=2 with rsp0_ready=0 for 5 cycles. Expect rsp0_valid=1, result=1 held stable, no req*_ready during the stall, and return to IDLE one edge after rsp0_ready=1.
- Opcode 15 and full-width operands: a=32'hFFFF_FFFF, b=32'h1, op=15. Expect the result equal to the ALU default output, forwarded unmodified.
- Reset mid-operation: assert rst during EXEC. Expect all outputs at reset values immediately, no rsp_valid after release, and requester 0 granted first on the next tie.
